// File: rtl/debounce_edge_pkg.sv
// debounce_edge_pkg: FSM state encodings, synchroniser depth limits and a counter-fit helper
package debounce_edge_pkg;
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    WAIT_LO = 2'b10,
    IDLE_HI = 2'b11
  } state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  function automatic bit cnt_fits(int n, int w);
    return w >= 31 || n <= (1 << w) - 1;
  endfunction
endpackage

// File: rtl/debounce_edge_if.sv
// debounce_edge_if: raw input plus debounced level, rise/fall pulses and busy; slave = debouncer, master = user
interface debounce_edge_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;
  modport slave (input din, output dout, rise, fall, busy);
  modport master(output din, input dout, rise, fall, busy);
endinterface

// File: rtl/debounce_edge_sync_ff_chain.sv
// debounce_edge_sync_ff_chain: STAGES-deep synchroniser; clk, rst (async active-low, clears to 0), d raw in, q synchronised out
module debounce_edge_sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: synchronise din, accept a new level after STABLE_CYCLES equal samples; clk, rst (async active-low), bus (slave)
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input logic           clk,
  input logic           rst,
  debounce_edge_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s;
  if (!cnt_fits(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
    $error("debounce_edge: CNT_W=%0d too small for STABLE_CYCLES=%0d", CNT_W, STABLE_CYCLES);
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("debounce_edge: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end
  debounce_edge_sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.din),
    .q  (s)
  );
  // a reversal in a WAIT state drops all progress; commit happens on the STABLE_CYCLES-th equal sample
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      bus.dout <= 1'b0;
      bus.rise <= 1'b0;
      bus.fall <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.rise <= 1'b0;
      bus.fall <= 1'b0;
      case (state)
        IDLE_LO:
          if (s) begin
            state    <= WAIT_HI;
            cnt      <= CNT_W'(1);
            bus.busy <= 1'b1;
          end
        WAIT_HI:
          if (!s) begin
            state    <= IDLE_LO;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else if (cnt == LAST) begin
            state    <= IDLE_HI;
            cnt      <= '0;
            bus.dout <= 1'b1;
            bus.rise <= 1'b1;
            bus.busy <= 1'b0;
          end else cnt <= cnt + 1'b1;
        IDLE_HI:
          if (!s) begin
            state    <= WAIT_LO;
            cnt      <= CNT_W'(1);
            bus.busy <= 1'b1;
          end
        WAIT_LO:
          if (s) begin
            state    <= IDLE_HI;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else if (cnt == LAST) begin
            state    <= IDLE_LO;
            cnt      <= '0;
            bus.dout <= 1'b0;
            bus.fall <= 1'b1;
            bus.busy <= 1'b0;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed checks of debounce_edge with SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=4
module tb_debounce_edge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   both_cnt = 0;
  int   r0;
  int   f0;
  debounce_edge_if bus ();
  debounce_edge #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    rise_cnt += int'(bus.rise);
    fall_cnt += int'(bus.fall);
    both_cnt += int'(bus.rise && bus.fall);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input int d, input int r, input int f, input int b);
    chk({tag, ".dout"}, int'(bus.dout), d);
    chk({tag, ".rise"}, int'(bus.rise), r);
    chk({tag, ".fall"}, int'(bus.fall), f);
    chk({tag, ".busy"}, int'(bus.busy), b);
  endtask
  initial begin
    bus.din = 1'b0;
    step(2);
    outs("reset", 0, 0, 0, 0);
    rst = 1'b1;
    step(3);
    outs("idle_lo", 0, 0, 0, 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    bus.din = 1'b1;
    step(2);
    outs("rise_e2", 0, 0, 0, 0);
    step(1);
    outs("rise_e3", 0, 0, 0, 1);
    step(2);
    outs("rise_e5", 0, 0, 0, 1);
    step(1);
    outs("rise_e6", 1, 1, 0, 0);
    step(1);
    outs("rise_e7", 1, 0, 0, 0);
    chk("rise_pulses", rise_cnt - r0, 1);
    r0 = rise_cnt;
    bus.din = 1'b0;
    step(2);
    outs("fall_e2", 1, 0, 0, 0);
    step(3);
    outs("fall_e5", 1, 0, 0, 1);
    step(1);
    outs("fall_e6", 0, 0, 1, 0);
    step(1);
    outs("fall_e7", 0, 0, 0, 0);
    chk("fall_pulses", fall_cnt - f0, 1);
    chk("fall_no_rise", rise_cnt - r0, 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    bus.din = 1'b1;
    step(2);
    bus.din = 1'b0;
    step(1);
    outs("glitch_e3", 0, 0, 0, 1);
    step(1);
    outs("glitch_e4", 0, 0, 0, 1);
    step(1);
    outs("glitch_e5", 0, 0, 0, 0);
    step(6);
    outs("glitch_end", 0, 0, 0, 0);
    chk("glitch_no_rise", rise_cnt - r0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.din = ~bus.din;
      step(1);
      chk("bounce_dout", int'(bus.dout), 0);
    end
    bus.din = 1'b1;
    step(5);
    outs("bounce_e5", 0, 0, 0, 1);
    step(1);
    outs("bounce_e6", 1, 1, 0, 0);
    step(3);
    chk("bounce_rise_once", rise_cnt - r0, 1);
    chk("bounce_no_fall", fall_cnt - f0, 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    bus.din = 1'b0;
    step(4);
    outs("midq_e4", 1, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    outs("midq_async", 0, 0, 0, 0);
    bus.din = 1'b1;
    #1 rst = 1'b1;
    step(5);
    outs("midq_rel_e5", 0, 0, 0, 1);
    step(1);
    outs("midq_rel_e6", 1, 1, 0, 0);
    step(2);
    chk("midq_no_fall", fall_cnt - f0, 0);
    chk("midq_rise_once", rise_cnt - r0, 1);
    r0 = rise_cnt;
    rst = 1'b0;
    step(3);
    outs("rst_hi_in", 0, 0, 0, 0);
    rst = 1'b1;
    step(1);
    outs("rst_hi_e1", 0, 0, 0, 0);
    step(4);
    outs("rst_hi_e5", 0, 0, 0, 1);
    step(1);
    outs("rst_hi_e6", 1, 1, 0, 0);
    step(1);
    outs("rst_hi_e7", 1, 0, 0, 0);
    chk("rst_hi_rise_once", rise_cnt - r0, 1);
    chk("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
